// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// regfile_write_arbiter: round-robin arbiter for the register file write port
// (ALU vs load writeback); optional post-reset clear under REGFILE_CLEAR_EN.
// Revision: 1.0
// ============================================================================
module regfile_write_arbiter #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iAValid,
    input  logic [ADDRESS_WIDTH-1:0] iAAddr,
    input  logic [DATA_WIDTH-1:0]    iAData,
    output logic                     oAReady,
    input  logic                     iBValid,
    input  logic [ADDRESS_WIDTH-1:0] iBAddr,
    input  logic [DATA_WIDTH-1:0]    iBData,
    output logic                     oBReady,
    output logic                     oWriteEn,
    output logic [ADDRESS_WIDTH-1:0] oWriteAddress,
    output logic [DATA_WIDTH-1:0]    oDataIn,
    output logic                     oBusy
);

    logic clearing;
    logic prio_b;     // 1: B wins the next contended cycle
    logic a_zero;
    logic b_zero;
    logic a_comp;
    logic b_comp;
    logic grant_a;
    logic grant_b;

`ifdef REGFILE_CLEAR_EN
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] clr_cnt;

    assign clearing = (state == ST_CLEAR);
`else
    assign clearing = 1'b0;
`endif

    assign oBusy = clearing;

    assign a_zero = (iAAddr == '0);
    assign b_zero = (iBAddr == '0);
    assign a_comp = !clearing && iAValid && !a_zero;
    assign b_comp = !clearing && iBValid && !b_zero;

    assign grant_a = a_comp && (!b_comp || !prio_b);
    assign grant_b = b_comp && (!a_comp || prio_b);

    // x0 writes are acknowledged outright and never touch the port or priority
    assign oAReady = !clearing && iAValid && (a_zero || grant_a);
    assign oBReady = !clearing && iBValid && (b_zero || grant_b);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            oWriteEn      <= 1'b0;
            oWriteAddress <= '0;
            oDataIn       <= '0;
            prio_b        <= 1'b0;
`ifdef REGFILE_CLEAR_EN
            state         <= ST_CLEAR;
            clr_cnt       <= ADDRESS_WIDTH'(1);
`endif
        end else if (clearing) begin
`ifdef REGFILE_CLEAR_EN
            oWriteEn      <= 1'b1;
            oWriteAddress <= clr_cnt;
            oDataIn       <= '0;
            clr_cnt       <= clr_cnt + ADDRESS_WIDTH'(1);
            if (clr_cnt == {ADDRESS_WIDTH{1'b1}}) begin
                state <= ST_RUN;
            end
`endif
        end else if (grant_a) begin
            oWriteEn      <= 1'b1;
            oWriteAddress <= iAAddr;
            oDataIn       <= iAData;
            prio_b        <= 1'b1;
        end else if (grant_b) begin
            oWriteEn      <= 1'b1;
            oWriteAddress <= iBAddr;
            oDataIn       <= iBData;
            prio_b        <= 1'b0;
        end else begin
            oWriteEn      <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// tb_regfile_write_arbiter: directed table, corner sequences and randomized
// traffic against a behavioural arbiter/register-file model.
// Revision: 1.0
// ============================================================================
module tb_regfile_write_arbiter;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 32;
`ifdef REGFILE_CLEAR_EN
    localparam logic BUSY_RST = 1'b1;
`else
    localparam logic BUSY_RST = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          a_valid, b_valid;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data, b_data;
    logic          a_ready, b_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          busy;

    regfile_write_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .iClk(clk), .iRst(rst),
        .iAValid(a_valid), .iAAddr(a_addr), .iAData(a_data), .oAReady(a_ready),
        .iBValid(b_valid), .iBAddr(b_addr), .iBData(b_data), .oBReady(b_ready),
        .oWriteEn(we), .oWriteAddress(waddr), .oDataIn(wdata), .oBusy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] rf_dut [NREG];
    logic [DW-1:0] m_rf   [NREG];
    logic          m_prio_b;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;

    typedef struct {
        logic av; logic [AW-1:0] aa; logic [DW-1:0] ad;
        logic bv; logic [AW-1:0] ba; logic [DW-1:0] bd;
        logic ar; logic br; logic ew; logic [AW-1:0] ea; logic [DW-1:0] ed;
    } vec_t;

    vec_t vt [16];

    function automatic vec_t mk(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                                input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                                input logic ar, input logic br, input logic ew,
                                input logic [AW-1:0] ea, input logic [DW-1:0] ed);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
        v.ar = ar; v.br = br; v.ew = ew; v.ea = ea; v.ed = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: port users are the nonzero-address valid requests; x0 is free.
    task automatic model(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                         output logic ar, output logic br, output logic ew,
                         output logic [AW-1:0] ea, output logic [DW-1:0] ed);
        bit a_wants;
        bit b_wants;
        int winner;
        a_wants = av && (aa != 0);
        b_wants = bv && (ba != 0);
        if (a_wants && b_wants) winner = m_prio_b ? 1 : 0;
        else if (a_wants)       winner = 0;
        else if (b_wants)       winner = 1;
        else                    winner = -1;
        ar = av && ((aa == 0) || (winner == 0));
        br = bv && ((ba == 0) || (winner == 1));
        if (winner == 0) begin
            m_addr = aa; m_data = ad; m_rf[aa] = ad; m_prio_b = 1'b1;
        end else if (winner == 1) begin
            m_addr = ba; m_data = bd; m_rf[ba] = bd; m_prio_b = 1'b0;
        end
        ew = (winner >= 0);
        ea = m_addr;
        ed = m_data;
    endtask

    task automatic model_reset();
        m_prio_b = 1'b0;
`ifdef REGFILE_CLEAR_EN
        for (int i = 1; i < NREG; i++) m_rf[i] = '0;
        m_addr = AW'(NREG - 1);
`else
        m_addr = '0;
`endif
        m_data = '0;
    endtask

    task automatic step(input string tag,
                        input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                        input logic ar, input logic br, input logic ew,
                        input logic [AW-1:0] ea, input logic [DW-1:0] ed);
        @(negedge clk);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
        #1;
        check({tag, " a_ready"}, 32'(a_ready), 32'(ar));
        check({tag, " b_ready"}, 32'(b_ready), 32'(br));
        @(posedge clk);
        #1;
        check({tag, " write_en"}, 32'(we), 32'(ew));
        check({tag, " write_addr"}, 32'(waddr), 32'(ea));
        check({tag, " write_data"}, wdata, ed);
        if (we) rf_dut[waddr] = wdata;
    endtask

    // Entered just after reset is released on a falling edge.
    task automatic clear_seq();
`ifdef REGFILE_CLEAR_EN
        for (int k = 1; k < NREG; k++) begin
            #1;
            check("clear a_ready", 32'(a_ready), 32'd0);
            check("clear b_ready", 32'(b_ready), 32'd0);
            check("clear busy", 32'(busy), 32'd1);
            @(posedge clk);
            #1;
            check("clear write_en", 32'(we), 32'd1);
            check("clear write_addr", 32'(waddr), 32'(k));
            check("clear write_data", wdata, 32'd0);
            if (we) rf_dut[waddr] = wdata;
            if (k < NREG - 1) @(negedge clk);
        end
`else
        #1;
`endif
        check("busy after clear", 32'(busy), 32'd0);
    endtask

    logic          pa, pb;
    logic [AW-1:0] paa, pba;
    logic [DW-1:0] pad, pbd;
    logic          e_ar, e_br, e_we;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d;

    initial begin
        rst = 1'b1;
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
        for (int i = 0; i < NREG; i++) begin
            rf_dut[i] = '0;
            m_rf[i]   = '0;
        end

        repeat (2) @(posedge clk);
        #1;
        check("reset write_en", 32'(we), 32'd0);
        check("reset write_addr", 32'(waddr), 32'd0);
        check("reset write_data", wdata, 32'd0);
        check("reset busy", 32'(busy), 32'(BUSY_RST));
        check("reset a_ready", 32'(a_ready), 32'd0);
        check("reset b_ready", 32'(b_ready), 32'd0);

        @(negedge clk);
`ifdef REGFILE_CLEAR_EN
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h5555;
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h7777;
`endif
        rst = 1'b0;
        clear_seq();
        a_valid = 1'b0;
        b_valid = 1'b0;
        model_reset();

        vt[0]  = mk(1'b1, 5'd1, 32'hA1,       1'b1, 5'd2, 32'hB1, 1'b1, 1'b0, 1'b1, 5'd1, 32'hA1);
        vt[1]  = mk(1'b1, 5'd3, 32'hA2,       1'b1, 5'd2, 32'hB1, 1'b0, 1'b1, 1'b1, 5'd2, 32'hB1);
        vt[2]  = mk(1'b1, 5'd3, 32'hA2,       1'b1, 5'd4, 32'hB2, 1'b1, 1'b0, 1'b1, 5'd3, 32'hA2);
        vt[3]  = mk(1'b1, 5'd5, 32'hA3,       1'b1, 5'd4, 32'hB2, 1'b0, 1'b1, 1'b1, 5'd4, 32'hB2);
        vt[4]  = mk(1'b1, 5'd5, 32'hA3,       1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b1, 5'd5, 32'hA3);
        vt[5]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd5, 32'hA3);
        vt[6]  = mk(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF);
        vt[7]  = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF);
        vt[8]  = mk(1'b1, 5'd0, 32'h55,       1'b1, 5'd7, 32'h77, 1'b1, 1'b1, 1'b1, 5'd7, 32'h77);
        vt[9]  = mk(1'b1, 5'd0, 32'h66,       1'b0, 5'd0, 32'h0,  1'b1, 1'b0, 1'b0, 5'd7, 32'h77);
        vt[10] = mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h99, 1'b0, 1'b1, 1'b0, 5'd7, 32'h77);
        vt[11] = mk(1'b1, 5'd6, 32'h61,       1'b1, 5'd8, 32'h81, 1'b1, 1'b0, 1'b1, 5'd6, 32'h61);
        vt[12] = mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd8, 32'h81, 1'b0, 1'b1, 1'b1, 5'd8, 32'h81);
        vt[13] = mk(1'b1, 5'd3, 32'h11,       1'b1, 5'd3, 32'h22, 1'b1, 1'b0, 1'b1, 5'd3, 32'h11);
        vt[14] = mk(1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 32'h22, 1'b0, 1'b1, 1'b1, 5'd3, 32'h22);
        vt[15] = mk(1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 1'b0, 5'd3, 32'h22);

        for (int i = 0; i < 16; i++) begin
            model(vt[i].av, vt[i].aa, vt[i].ad, vt[i].bv, vt[i].ba, vt[i].bd, e_ar, e_br, e_we, e_a, e_d);
            step($sformatf("vec%0d", i), vt[i].av, vt[i].aa, vt[i].ad, vt[i].bv, vt[i].ba, vt[i].bd,
                 vt[i].ar, vt[i].br, vt[i].ew, vt[i].ea, vt[i].ed);
        end
        check("same-addr reg3", rf_dut[3], 32'h22);

        pa = 1'b0; pb = 1'b0; paa = '0; pba = '0; pad = '0; pbd = '0;
        for (int c = 0; c < 400; c++) begin
            if (!pa && ($urandom_range(0, 2) != 0)) begin
                pa  = 1'b1;
                paa = ($urandom_range(0, 4) == 0) ? '0 : AW'($urandom_range(1, NREG - 1));
                pad = $urandom;
            end
            if (!pb && ($urandom_range(0, 2) != 0)) begin
                pb  = 1'b1;
                pba = ($urandom_range(0, 4) == 0) ? '0 : AW'($urandom_range(1, NREG - 1));
                pbd = $urandom;
            end
            model(pa, paa, pad, pb, pba, pbd, e_ar, e_br, e_we, e_a, e_d);
            step("rand", pa, paa, pad, pb, pba, pbd, e_ar, e_br, e_we, e_a, e_d);
            if (e_ar) pa = 1'b0;
            if (e_br) pb = 1'b0;
        end

        // Leave priority with B so the post-reset grant shows the pointer reset.
        model(1'b1, 5'd15, 32'hF15, 1'b0, 5'd0, 32'h0, e_ar, e_br, e_we, e_a, e_d);
        step("pre-reset", 1'b1, 5'd15, 32'hF15, 1'b0, 5'd0, 32'h0, e_ar, e_br, e_we, e_a, e_d);

        @(negedge clk);
        rst = 1'b1;
        a_valid = 1'b1; a_addr = 5'd12; a_data = 32'hC0C00012;
        b_valid = 1'b1; b_addr = 5'd14; b_data = 32'hE0E00014;
        @(posedge clk);
        #1;
        check("midreset write_en", 32'(we), 32'd0);
        check("midreset write_addr", 32'(waddr), 32'd0);
        check("midreset write_data", wdata, 32'd0);
        check("midreset busy", 32'(busy), 32'(BUSY_RST));
`ifdef REGFILE_CLEAR_EN
        check("midreset a_ready", 32'(a_ready), 32'd0);
`endif
        @(negedge clk);
`ifndef REGFILE_CLEAR_EN
        a_valid = 1'b0;
        b_valid = 1'b0;
`endif
        rst = 1'b0;
        model_reset();
        clear_seq();

        model(1'b1, 5'd12, 32'hC0C00012, 1'b1, 5'd14, 32'hE0E00014, e_ar, e_br, e_we, e_a, e_d);
        step("post-reset contend", 1'b1, 5'd12, 32'hC0C00012, 1'b1, 5'd14, 32'hE0E00014,
             1'b1, 1'b0, 1'b1, 5'd12, 32'hC0C00012);
        model(1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'hE0E00014, e_ar, e_br, e_we, e_a, e_d);
        step("post-reset b", 1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'hE0E00014,
             1'b0, 1'b1, 1'b1, 5'd14, 32'hE0E00014);
        model(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, e_ar, e_br, e_we, e_a, e_d);
        step("post-reset idle", 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
             1'b0, 1'b0, 1'b0, 5'd14, 32'hE0E00014);

        for (int i = 0; i < NREG; i++) begin
            check($sformatf("regfile[%0d]", i), rf_dut[i], m_rf[i]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
